// File: rtl/cvxif_issue_arb_if.sv
// rtl/cvxif_issue_arb_if.sv - requester and CV-X-IF issue/result signal bundle for the issue arbiter
interface cvxif_issue_arb_if #(
   parameter int unsigned NR_REQ          = 2,
   parameter int unsigned TRANS_ID_BITS   = 3,
   parameter int unsigned MAX_OUTSTANDING = 4
);
   localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   // requester side
   logic [NR_REQ-1:0]                    req_valid_i;
   logic [NR_REQ-1:0]                    req_ready_o;
   logic [NR_REQ-1:0][31:0]              req_instr_i;
   logic [NR_REQ-1:0][TRANS_ID_BITS-1:0] req_id_i;

   // coprocessor issue side
   logic                     x_issue_valid_o;
   logic                     x_issue_ready_i;
   logic                     x_issue_accept_i;
   logic [31:0]              x_issue_instr_o;
   logic [TRANS_ID_BITS-1:0] x_issue_id_o;

   // coprocessor result side
   logic                     x_result_valid_i;
   logic [TRANS_ID_BITS-1:0] x_result_id_i;
   logic [IDX_W-1:0]         result_owner_o;

   // reject reporting, occupancy and flush
   logic                     reject_valid_o;
   logic [TRANS_ID_BITS-1:0] reject_id_o;
   logic [31:0]              reject_instr_o;
   logic [CNT_W-1:0]         outstanding_o;
   logic                     flush_i;

   // arbiter side
   modport master (
      input  req_valid_i, req_instr_i, req_id_i,
      input  x_issue_ready_i, x_issue_accept_i,
      input  x_result_valid_i, x_result_id_i, flush_i,
      output req_ready_o, x_issue_valid_o, x_issue_instr_o, x_issue_id_o,
      output result_owner_o, reject_valid_o, reject_id_o, reject_instr_o,
      output outstanding_o
   );

   // requesters plus coprocessor
   modport slave (
      output req_valid_i, req_instr_i, req_id_i,
      output x_issue_ready_i, x_issue_accept_i,
      output x_result_valid_i, x_result_id_i, flush_i,
      input  req_ready_o, x_issue_valid_o, x_issue_instr_o, x_issue_id_o,
      input  result_owner_o, reject_valid_o, reject_id_o, reject_instr_o,
      input  outstanding_o
   );
endinterface

// File: rtl/cvxif_issue_arb.sv
// rtl/cvxif_issue_arb.sv - round-robin arbiter sharing one CV-X-IF issue port among NR_REQ requesters
module cvxif_issue_arb #(
   parameter int unsigned NR_REQ          = 2,
   parameter int unsigned TRANS_ID_BITS   = 3,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   cvxif_issue_arb_if.master bus
);
   localparam int unsigned IDX_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
   localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned NR_IDS = 1 << TRANS_ID_BITS;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NR_REQ - 1);

   // registered state
   logic [IDX_W-1:0]         last_grant_q, last_grant_d;
   logic                     lock_q, lock_d;
   logic [IDX_W-1:0]         lock_idx_q, lock_idx_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]         owner_q [NR_IDS];
   logic [IDX_W-1:0]         owner_d [NR_IDS];
   logic                     rej_valid_q, rej_valid_d;
   logic [TRANS_ID_BITS-1:0] rej_id_q, rej_id_d;
   logic [31:0]              rej_instr_q, rej_instr_d;

   // combinational arbitration signals
   int unsigned              rr_cand;
   logic                     rr_found;
   logic [IDX_W-1:0]         rr_idx;
   logic [IDX_W-1:0]         grant_idx;
   logic                     any_valid;
   logic                     full;
   logic                     issue_valid;
   logic                     handshake;
   logic                     accepted;
   logic                     rejected;
   logic                     retire;
   logic                     show_reject;
   logic [31:0]              issue_instr;
   logic [TRANS_ID_BITS-1:0] issue_id;

   // Round-robin search: first valid requester starting just after the last granted one
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      rr_cand  = 0;
      for (int unsigned k = 1; k <= NR_REQ; k++) begin
         rr_cand = 32'(last_grant_q) + k;
         if (rr_cand >= NR_REQ) begin
            rr_cand = rr_cand - NR_REQ;
         end
         if (!rr_found && bus.req_valid_i[IDX_W'(rr_cand)]) begin
            rr_found = 1'b1;
            rr_idx   = IDX_W'(rr_cand);
         end
      end
   end

   // Grant selection, issue qualification and handshake classification
   always_comb begin
      any_valid   = |bus.req_valid_i;
      full        = (cnt_q == CNT_MAX);
      // A stalled offload keeps its slot so the coprocessor sees a stable request
      grant_idx   = (lock_q && bus.req_valid_i[lock_idx_q]) ? lock_idx_q : rr_idx;
      // Reset and flush both hide the request so no handshake can be counted
      issue_valid = rst_ni && !bus.flush_i && any_valid && !full;
      handshake   = issue_valid && bus.x_issue_ready_i;
      accepted    = handshake && bus.x_issue_accept_i;
      rejected    = handshake && !bus.x_issue_accept_i;
      retire      = bus.x_result_valid_i && (cnt_q != '0);
      issue_instr = '0;
      issue_id    = '0;
      if (issue_valid) begin
         issue_instr = bus.req_instr_i[grant_idx];
         issue_id    = bus.req_id_i[grant_idx];
      end
   end

   // Output drive: everything idles at zero when not qualified
   always_comb begin
      bus.x_issue_valid_o = issue_valid;
      bus.x_issue_instr_o = issue_instr;
      bus.x_issue_id_o    = issue_id;
      bus.req_ready_o     = '0;
      if (handshake) begin
         bus.req_ready_o[grant_idx] = 1'b1;
      end
      bus.result_owner_o = '0;
      if (rst_ni && bus.x_result_valid_i) begin
         bus.result_owner_o = owner_q[bus.x_result_id_i];
      end
      // A flush arriving while the reject pulse is due cancels that pulse
      show_reject        = rej_valid_q && !bus.flush_i;
      bus.reject_valid_o = show_reject;
      bus.reject_id_o    = show_reject ? rej_id_q    : '0;
      bus.reject_instr_o = show_reject ? rej_instr_q : '0;
      bus.outstanding_o  = cnt_q;
   end

   // Next-state: grant history, lock, outstanding count, owner table, reject capture
   always_comb begin
      last_grant_d = last_grant_q;
      if (handshake) begin
         last_grant_d = grant_idx;
      end

      lock_d     = issue_valid && !bus.x_issue_ready_i;
      lock_idx_d = lock_d ? grant_idx : '0;

      // Simultaneous issue and retire cancel out; full blocks issue so no overflow
      cnt_d = cnt_q;
      if (accepted && !retire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!accepted && retire) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      owner_d = owner_q;
      if (accepted) begin
         owner_d[issue_id] = grant_idx;
      end

      rej_valid_d = rejected;
      rej_id_d    = rejected ? issue_id    : '0;
      rej_instr_d = rejected ? issue_instr : '0;
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_grant_q <= LAST_RST;
         lock_q       <= 1'b0;
         lock_idx_q   <= '0;
         cnt_q        <= '0;
         for (int i = 0; i < NR_IDS; i++) begin
            owner_q[i] <= '0;
         end
         rej_valid_q  <= 1'b0;
         rej_id_q     <= '0;
         rej_instr_q  <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         lock_q       <= lock_d;
         lock_idx_q   <= lock_idx_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         rej_valid_q  <= rej_valid_d;
         rej_id_q     <= rej_id_d;
         rej_instr_q  <= rej_instr_d;
      end
   end
endmodule
